// File: rtl/calc_pkg.sv
// Shared constants and helpers for the binary calculator datapath.
//   clog2        : ceiling log2 used to size select/index fields
//   MAX_CHANNELS : upper bound on operand channels for any arbiter
//   ARB_RR/FIXED : arbitration mode encodings shared by all arbiters
package calc_pkg;

    localparam int unsigned MAX_CHANNELS = 16;

    localparam logic ARB_RR    = 1'b1;
    localparam logic ARB_FIXED = 1'b0;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin (search starts after i_ptr, wrapping)
// or fixed priority (lowest index wins), selected by i_mode.
//   i_req     : per-channel request vector
//   i_ptr     : index of the last granted channel (RR mode only)
//   i_mode    : ARB_RR or ARB_FIXED
//   i_enable  : when low, no grant is issued
//   o_grant_c : one-hot grant
//   o_idx_c   : encoded index of the granted channel
//   o_valid_c : a grant was issued
module rr_arbiter
    import calc_pkg::*;
#(
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SELW     = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SELW-1:0]     i_ptr,
    input  logic                i_mode,
    input  logic                i_enable,
    output logic [CHANNELS-1:0] o_grant_c,
    output logic [SELW-1:0]     o_idx_c,
    output logic                o_valid_c
);

    logic [SELW-1:0] w_cand;

    // Priority search; the first hit freezes the result.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        w_cand    = '0;
        if (i_enable) begin
            if (i_mode == ARB_RR) begin
                for (int unsigned k = 1; k <= CHANNELS; k++) begin
                    w_cand = SELW'((32'(i_ptr) + k) % CHANNELS);
                    if (!o_valid_c && i_req[w_cand]) begin
                        o_valid_c = 1'b1;
                        o_idx_c   = w_cand;
                    end
                end
            end else begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (!o_valid_c && i_req[i]) begin
                        o_valid_c = 1'b1;
                        o_idx_c   = SELW'(i);
                    end
                end
            end
            if (o_valid_c) begin
                o_grant_c[o_idx_c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_operand_mux.sv
// N-channel operand selector: arbitrates among valid sources and passes the
// winner through one registered output stage with valid/ready on both sides.
//   clk, rst_n           : clock, async active-low reset
//   in_data/in_valid     : packed channel data (channel i at [i*WIDTH +: WIDTH])
//   in_ready             : per-channel accept, at most one bit high
//   force_en/force_sel   : restrict eligibility to a single channel
//   out_data/out_sel     : registered winner data and its channel index
//   out_valid/out_ready  : output handshake
module rr_operand_mux
    import calc_pkg::*;
#(
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned CHANNELS = 4,
    parameter  bit          RR_MODE  = 1'b1,
    localparam int unsigned SELW     = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SELW-1:0]           force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("rr_operand_mux: CHANNELS out of range");
    end

    logic [SELW-1:0]       r_ptr;
    logic [WIDTH-1:0]      r_data;
    logic [SELW-1:0]       r_sel;
    logic                  r_valid;

    logic                  w_load_en;
    logic [CHANNELS-1:0]   w_force_mask;
    logic [CHANNELS-1:0]   w_req;
    logic [CHANNELS-1:0]   w_grant;
    logic [SELW-1:0]       w_idx;
    logic                  w_gnt_valid;
    logic                  w_xfer;
    logic [WIDTH-1:0]      w_sel_data;

    // Output stage can take a word when empty or draining this cycle.
    assign w_load_en = !r_valid || out_ready;

    // Decode force_sel; an index >= CHANNELS matches no bit, so no grant.
    always_comb begin
        w_force_mask = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_force_mask[i] = (force_sel == SELW'(i));
        end
    end

    assign w_req = force_en ? (in_valid & w_force_mask) : in_valid;

    // Gating with rst_n keeps in_ready low for the whole reset assertion.
    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .i_mode    (RR_MODE ? ARB_RR : ARB_FIXED),
        .i_enable  (w_load_en && rst_n),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx),
        .o_valid_c (w_gnt_valid)
    );

    assign in_ready = w_grant;
    assign w_xfer   = w_gnt_valid && |(in_valid & w_grant);

    // One-hot AND-OR data mux.
    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= SELW'(CHANNELS - 1);
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_data  <= w_sel_data;
                r_sel   <= w_idx;
                r_valid <= 1'b1;
                if (RR_MODE) begin
                    r_ptr <= w_idx;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_operand_mux.sv
module tb_rr_operand_mux;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned CHANNELS = 4;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
    } exp_t;

    logic                      clk;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic                      force_en;
    logic [1:0]                force_sel;
    logic                      out_ready;

    logic [CHANNELS-1:0]       rr_in_ready, fx_in_ready;
    logic [WIDTH-1:0]          rr_out_data, fx_out_data;
    logic [1:0]                rr_out_sel,  fx_out_sel;
    logic                      rr_out_valid, fx_out_valid;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    rr_operand_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_data(rr_out_data), .out_sel(rr_out_sel), .out_valid(rr_out_valid),
        .out_ready(out_ready)
    );

    rr_operand_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .RR_MODE(1'b0)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fx_in_ready), .force_en(force_en), .force_sel(force_sel),
        .out_data(fx_out_data), .out_sel(fx_out_sel), .out_valid(fx_out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        force_en  = 1'b0;
        force_sel = '0;
        out_ready = 1'b1;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        force_en  = 1'b0;
        force_sel = '0;
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        n_cmp++; if (rr_in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0000", rr_in_ready); end
        n_cmp++; if (fx_in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_fx_in_ready: got %b want 0000", fx_in_ready); end
        n_cmp++; if (rr_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", rr_out_valid); end
        n_cmp++; if (rr_out_data !== 4'h0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", rr_out_data); end
        n_cmp++; if (rr_out_sel !== 2'd0) begin n_bad++; $display("FAIL reset_out_sel: got %0d want 0", rr_out_sel); end
        rst_n = 1'b1;
        sb.push_back('{sel: 2'd0, data: 4'h0});
        next_cycle();
        e = sb.pop_front();
        n_cmp++; if (rr_out_valid !== 1'b1) begin n_bad++; $display("FAIL reset_first_valid: got %b want 1", rr_out_valid); end
        n_cmp++; if (rr_out_sel !== e.sel) begin n_bad++; $display("FAIL reset_first_sel: got %0d want %0d", rr_out_sel, e.sel); end
        n_cmp++; if (rr_out_data !== e.data) begin n_bad++; $display("FAIL reset_first_data: got %h want %h", rr_out_data, e.data); end
    endtask

    task automatic test_rr_fairness();
        exp_t seq[6];
        seq = '{'{2'd0, 4'h0}, '{2'd1, 4'hF}, '{2'd2, 4'hA},
                '{2'd3, 4'h5}, '{2'd0, 4'h0}, '{2'd1, 4'hF}};
        do_reset();
        in_valid = 4'b1111;
        foreach (seq[i]) sb.push_back(seq[i]);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            e = sb.pop_front();
            n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_sel !== e.sel || rr_out_data !== e.data) begin
                n_bad++; $display("FAIL rr_fair[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                                  i, rr_out_valid, rr_out_sel, rr_out_data, e.sel, e.data);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{sel: 2'd1, data: 4'hF});
            next_cycle();
            e = sb.pop_front();
            n_cmp++; if (fx_out_valid !== 1'b1 || fx_out_sel !== e.sel || fx_out_data !== e.data) begin
                n_bad++; $display("FAIL fixed_ch1[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                                  i, fx_out_valid, fx_out_sel, fx_out_data, e.sel, e.data);
            end
            n_cmp++; if (fx_in_ready !== 4'b0010) begin n_bad++; $display("FAIL fixed_ready[%0d]: got %b want 0010", i, fx_in_ready); end
        end
        in_valid = 4'b1000;
        sb.push_back('{sel: 2'd3, data: 4'h5});
        next_cycle();
        e = sb.pop_front();
        n_cmp++; if (fx_out_valid !== 1'b1 || fx_out_sel !== e.sel || fx_out_data !== e.data) begin
            n_bad++; $display("FAIL fixed_ch3: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                              fx_out_valid, fx_out_sel, fx_out_data, e.sel, e.data);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        in_valid = 4'b1111;
        sb.push_back('{sel: 2'd0, data: 4'h0});
        next_cycle();
        e = sb.pop_front();
        n_cmp++; if (rr_out_sel !== e.sel || rr_out_data !== e.data) begin
            n_bad++; $display("FAIL bp_first: got sel=%0d data=%h want sel=%0d data=%h", rr_out_sel, rr_out_data, e.sel, e.data);
        end
        out_ready = 1'b0;
        #1;
        n_cmp++; if (rr_in_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready_now: got %b want 0000", rr_in_ready); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 4'h0 || rr_in_ready !== 4'b0000) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h rdy=%b want v=1 sel=0 data=0 rdy=0000",
                                  i, rr_out_valid, rr_out_sel, rr_out_data, rr_in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (rr_in_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_resume_ready: got %b want 0010", rr_in_ready); end
        sb.push_back('{sel: 2'd1, data: 4'hF});
        next_cycle();
        e = sb.pop_front();
        n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_sel !== e.sel || rr_out_data !== e.data) begin
            n_bad++; $display("FAIL bp_resume: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                              rr_out_valid, rr_out_sel, rr_out_data, e.sel, e.data);
        end
    endtask

    task automatic test_force();
        do_reset();
        in_valid  = 4'b1111;
        force_en  = 1'b1;
        force_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (rr_in_ready !== 4'b0100) begin n_bad++; $display("FAIL force_ready[%0d]: got %b want 0100", i, rr_in_ready); end
            sb.push_back('{sel: 2'd2, data: 4'hA});
            next_cycle();
            e = sb.pop_front();
            n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_sel !== e.sel || rr_out_data !== e.data) begin
                n_bad++; $display("FAIL force_word[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                                  i, rr_out_valid, rr_out_sel, rr_out_data, e.sel, e.data);
            end
        end
        force_sel = 2'd3;
        in_valid  = 4'b0111;
        #1;
        n_cmp++; if (rr_in_ready !== 4'b0000) begin n_bad++; $display("FAIL force_invalid_ready: got %b want 0000", rr_in_ready); end
        next_cycle();
        n_cmp++; if (rr_out_valid !== 1'b0 || rr_out_sel !== 2'd2 || rr_out_data !== 4'hA) begin
            n_bad++; $display("FAIL force_drain: got v=%b sel=%0d data=%h want v=0 sel=2 data=a",
                              rr_out_valid, rr_out_sel, rr_out_data);
        end
        // Forced grants moved the pointer to 2, so the next free grant is 3.
        force_en = 1'b0;
        in_valid = 4'b1111;
        sb.push_back('{sel: 2'd3, data: 4'h5});
        next_cycle();
        e = sb.pop_front();
        n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_sel !== e.sel || rr_out_data !== e.data) begin
            n_bad++; $display("FAIL force_ptr: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                              rr_out_valid, rr_out_sel, rr_out_data, e.sel, e.data);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        in_valid = 4'b1111;
        next_cycle();
        next_cycle();
        out_ready = 1'b0;
        next_cycle();
        n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd1) begin
            n_bad++; $display("FAIL mid_pre: got v=%b sel=%0d want v=1 sel=1", rr_out_valid, rr_out_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rr_out_valid !== 1'b0 || rr_out_data !== 4'h0 || rr_in_ready !== 4'b0000) begin
            n_bad++; $display("FAIL mid_async: got v=%b data=%h rdy=%b want v=0 data=0 rdy=0000",
                              rr_out_valid, rr_out_data, rr_in_ready);
        end
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sb.push_back('{sel: 2'd0, data: 4'h0});
        next_cycle();
        e = sb.pop_front();
        n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_sel !== e.sel || rr_out_data !== e.data) begin
            n_bad++; $display("FAIL mid_restart: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                              rr_out_valid, rr_out_sel, rr_out_data, e.sel, e.data);
        end
    endtask

    initial begin
        in_data   = {4'h5, 4'hA, 4'hF, 4'h0};
        rst_n     = 1'b0;
        in_valid  = '0;
        force_en  = 1'b0;
        force_sel = '0;
        out_ready = 1'b1;
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_back_pressure();
        test_force();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
